// File: rtl/ula_pkg.sv
// Shared definitions for the ULA command sequencer: opcodes, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ula_pkg;

    localparam int ULA_N    = 8;
    localparam int ULA_PROF = 4;

    localparam logic [2:0] OP_SOMA        = 3'd0;
    localparam logic [2:0] OP_SUB         = 3'd1;
    localparam logic [2:0] OP_MAIOR       = 3'd2;
    localparam logic [2:0] OP_MENOR       = 3'd3;
    localparam logic [2:0] OP_MAIOR_IGUAL = 3'd4;
    localparam logic [2:0] OP_MENOR_IGUAL = 3'd5;
    localparam logic [2:0] OP_IGUAL       = 3'd6;
    localparam logic [2:0] OP_MULTI       = 3'd7;

    typedef enum logic [2:0] {
        OCIOSO,
        EMITE,
        ESPERA,
        CAPTURA,
        ENTREGA
    } estado_t;

endpackage

// File: rtl/ula_sequenciador_if.sv
// Command and result handshakes of the ULA sequencer bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready throttles the producer, res_ready throttles result delivery.
interface ula_sequenciador_if import ula_pkg::*; #(parameter int N = ULA_N);

    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
    logic [N-1:0]   cmd_a;
    logic [N-1:0]   cmd_b;

    logic           res_valid;
    logic           res_ready;
    logic [2:0]     res_op;
    logic [2*N-1:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_op, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_op, res_data
    );

endinterface

// File: rtl/fila_cmd.sv
// Synchronous FIFO of packed {op,a,b} commands with occupancy count.
// Latency: an entry pushed at one edge is visible on dout from the next edge (no bypass).
// Backpressure: full blocks further pushes; pop on empty is ignored.
module fila_cmd #(
    parameter  int W    = 19,
    parameter  int PROF = 4,
    localparam int AW   = $clog2(PROF)
) (
    input  logic          Tclk,
    input  logic          Tclr_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0] mem [PROF];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(PROF));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers; reset empties the queue.
    always_ff @(posedge Tclk) begin
        if (!Tclr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array, no reset needed: contents are only read behind the pointers.
    always_ff @(posedge Tclk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ula_sequenciador.sv
// Buffers ULA commands, drives one at a time into the ULA and returns the captured result.
// Latency: accept at edge Ea into idle block -> res_valid after Ea+4; 4-cycle issue interval.
// Backpressure: cmd_ready drops when the FIFO is full; results park in ENTREGA until res_ready.
module ula_sequenciador import ula_pkg::*; #(
    parameter int N    = ULA_N,
    parameter int PROF = ULA_PROF
) (
    input  logic                  Tclk,
    input  logic                  Tclr_n,
    ula_sequenciador_if.slave     bus,
    output logic [$clog2(PROF):0] ocupacao,
    output logic [N-1:0]          ula_A,
    output logic [N-1:0]          ula_B,
    output logic [2:0]            ula_selec,
    output logic                  ula_en,
    output logic                  ula_clr,
    output logic                  ula_pr,
    input  logic [N:0]            ula_S,
    input  logic [2*N-1:0]        ula_Smulti
);

    localparam int W = 3 + 2*N;

    estado_t        estado;
    logic           cheia;
    logic           vazia;
    logic           push;
    logic           pop;
    logic [W-1:0]   cab;
    logic           res_valid_q;
    logic [2:0]     res_op_q;
    logic [2*N-1:0] res_data_q;

    assign bus.cmd_ready = Tclr_n && !cheia;
    assign bus.res_valid = res_valid_q;
    assign bus.res_op    = res_op_q;
    assign bus.res_data  = res_data_q;

    assign ula_clr = !Tclr_n;
    assign ula_pr  = 1'b0;

    assign push = bus.cmd_valid && bus.cmd_ready;
    // A new command starts from idle, or on the very edge the previous result is taken.
    assign pop  = !vazia && ((estado == OCIOSO) || (estado == ENTREGA && bus.res_ready));

    fila_cmd #(.W(W), .PROF(PROF)) u_fila (
        .Tclk   (Tclk),
        .Tclr_n (Tclr_n),
        .push   (push),
        .din    ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
        .pop    (pop),
        .dout   (cab),
        .full   (cheia),
        .empty  (vazia),
        .count  (ocupacao)
    );

    // Sequencer FSM: hold ULA inputs for two settle edges, capture, then deliver downstream.
    always_ff @(posedge Tclk) begin
        if (!Tclr_n) begin
            estado      <= OCIOSO;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            ula_A       <= '0;
            ula_B       <= '0;
            ula_selec   <= '0;
            ula_en      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO:  ;
                EMITE:   estado <= ESPERA;
                ESPERA:  estado <= CAPTURA;
                CAPTURA: begin
                    res_data_q  <= (ula_selec == OP_MULTI) ? ula_Smulti
                                                           : {{(N-1){1'b0}}, ula_S};
                    res_valid_q <= 1'b1;
                    ula_en      <= 1'b0;
                    estado      <= ENTREGA;
                end
                ENTREGA: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        estado      <= OCIOSO;
                    end
                end
                default: estado <= OCIOSO;
            endcase
            // A pop overrides the idle fall-through and launches the next command.
            if (pop) begin
                ula_selec <= cab[W-1 -: 3];
                ula_A     <= cab[2*N-1 -: N];
                ula_B     <= cab[N-1:0];
                res_op_q  <= cab[W-1 -: 3];
                ula_en    <= 1'b1;
                estado    <= EMITE;
            end
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
module tb_ula_sequenciador;

    localparam int N    = 8;
    localparam int PROF = 4;

    typedef struct packed {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } cmd_t;

    logic                  Tclk = 1'b0;
    logic                  rst_n;
    logic [$clog2(PROF):0] ocupacao;
    logic [N-1:0]          ula_A;
    logic [N-1:0]          ula_B;
    logic [2:0]            ula_selec;
    logic                  ula_en;
    logic                  ula_clr;
    logic                  ula_pr;
    logic [N:0]            ula_S;
    logic [2*N-1:0]        ula_Smulti;

    int n_cmp = 0;
    int n_err = 0;

    ula_sequenciador_if #(.N(N)) bus();

    ula_sequenciador #(.N(N), .PROF(PROF)) dut (
        .Tclk       (Tclk),
        .Tclr_n     (rst_n),
        .bus        (bus),
        .ocupacao   (ocupacao),
        .ula_A      (ula_A),
        .ula_B      (ula_B),
        .ula_selec  (ula_selec),
        .ula_en     (ula_en),
        .ula_clr    (ula_clr),
        .ula_pr     (ula_pr),
        .ula_S      (ula_S),
        .ula_Smulti (ula_Smulti)
    );

    always #5 Tclk = ~Tclk;

    // ---------------- ULA stand-in: input registers, then output registers ----------
    function automatic logic [8:0] ula_s(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {8'd0, a > b};
            3'd3:    return {8'd0, a < b};
            3'd4:    return {8'd0, a >= b};
            3'd5:    return {8'd0, a <= b};
            3'd6:    return {8'd0, a == b};
            default: return '0;
        endcase
    endfunction

    logic [7:0]  ua, ub;
    logic [2:0]  usel;
    logic [8:0]  us;
    logic [15:0] usm;
    always @(posedge Tclk) begin
        if (ula_clr) begin
            ua <= '0; ub <= '0; usel <= '0; us <= '0; usm <= '0;
        end else if (ula_en) begin
            ua   <= ula_A;
            ub   <= ula_B;
            usel <= ula_selec;
            us   <= ula_s(usel, ua, ub);
            usm  <= 16'(ua) * 16'(ub);
        end
    end
    assign ula_S      = us;
    assign ula_Smulti = usm;

    // ---------------- checking helpers and reference arithmetic ----------------------
    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h, expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] resultado(input logic [2:0] op, input int a, input int b);
        int s;
        case (op)
            3'd0:    s = a + b;
            3'd1:    s = a - b + 512;
            3'd2:    s = (a > b)  ? 1 : 0;
            3'd3:    s = (a < b)  ? 1 : 0;
            3'd4:    s = (a >= b) ? 1 : 0;
            3'd5:    s = (a <= b) ? 1 : 0;
            3'd6:    s = (a == b) ? 1 : 0;
            default: return 16'(a * b);
        endcase
        return 16'(s % 512);
    endfunction

    // ---------------- behavioural model + per-cycle compare --------------------------
    cmd_t        fila[$];
    cmd_t        cur;
    bit          ocupado;
    int          idade;
    bit          rv;
    logic [15:0] rdat;
    logic [2:0]  rop;

    initial begin
        ocupado = 0; idade = 0; rv = 0; rdat = '0; rop = '0; cur = '0;
    end

    always @(negedge Tclk) begin
        bit aceita, entrega, inicia;
        chk("cmd_ready", bus.cmd_ready, rst_n && (fila.size() < PROF));
        chk("ocupacao",  ocupacao, fila.size());
        chk("res_valid", bus.res_valid, rv);
        chk("res_data",  bus.res_data, rdat);
        chk("res_op",    bus.res_op, rop);
        chk("ula_en",    ula_en, ocupado);
        chk("ula_A",     ula_A, cur.a);
        chk("ula_B",     ula_B, cur.b);
        chk("ula_selec", ula_selec, cur.op);
        chk("ula_clr",   ula_clr, !rst_n);
        chk("ula_pr",    ula_pr, 0);
        // advance the model across the coming rising edge (inputs are stable now)
        if (!rst_n) begin
            fila.delete();
            ocupado = 0; idade = 0; rv = 0; rdat = '0; rop = '0; cur = '0;
        end else begin
            aceita  = bus.cmd_valid && (fila.size() < PROF);
            entrega = rv && bus.res_ready;
            inicia  = (fila.size() > 0) && ((!ocupado && !rv) || entrega);
            if (entrega) rv = 0;
            if (ocupado) begin
                if (idade == 2) begin
                    ocupado = 0;
                    rv      = 1;
                    rdat    = resultado(cur.op, cur.a, cur.b);
                end else begin
                    idade++;
                end
            end else if (inicia) begin
                cur     = fila.pop_front();
                ocupado = 1;
                idade   = 0;
                rop     = cur.op;
            end
            if (aceita) fila.push_back({bus.cmd_op, bus.cmd_a, bus.cmd_b});
        end
    end

    // ---------------- stimulus ---------------------------------------------------
    task automatic tick();
        @(posedge Tclk); #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int  n = 0;
        logic ok;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
        do begin
            @(negedge Tclk); ok = bus.cmd_ready;
            @(posedge Tclk); #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("send_timeout", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int ciclos);
        ciclos = 0;
        do begin
            @(negedge Tclk); ciclos++;
        end while (!bus.res_valid && ciclos < 60);
        if (!bus.res_valid) chk("res_timeout", bus.res_valid, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int   c;
        cmd_t lote[5];
        logic [2:0] ops5[5] = '{3'd0, 3'd1, 3'd7, 3'd6, 3'd2};
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.res_ready = 1'b0;

        // reset state
        repeat (2) tick();
        @(negedge Tclk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_ocupacao",  ocupacao, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_ula_clr",   ula_clr, 1);
        tick();
        rst_n = 1'b1;

        // latency and soma
        bus.res_ready = 1'b1;
        send(3'd0, 8'd200, 8'd100);
        wait_res(c);
        chk("latency", c, 5);
        chk("soma_data", bus.res_data, 16'h012C);
        chk("soma_op", bus.res_op, 0);

        // multiplications
        tick();
        send(3'd7, 8'd200, 8'd200);
        wait_res(c);
        chk("multi_200", bus.res_data, 16'h9C40);
        tick();
        send(3'd7, 8'd15, 8'd17);
        wait_res(c);
        chk("multi_15", bus.res_data, 16'h00FF);
        chk("multi_op", bus.res_op, 7);

        // held result under backpressure
        tick();
        bus.res_ready = 1'b0;
        send(3'd1, 8'd50, 8'd20);
        wait_res(c);
        chk("sub_data", bus.res_data, 16'h001E);
        repeat (10) begin
            @(negedge Tclk);
            chk("hold_valid", bus.res_valid, 1);
            chk("hold_data", bus.res_data, 16'h001E);
        end
        @(posedge Tclk); #1; bus.res_ready = 1'b1;
        @(negedge Tclk); chk("pulse_valid_before", bus.res_valid, 1);
        @(posedge Tclk); #1; bus.res_ready = 1'b0;
        @(negedge Tclk); chk("pulse_valid_after", bus.res_valid, 0);

        // fill the FIFO behind a parked result
        tick();
        for (int i = 0; i < 5; i++) begin
            lote[i] = {ops5[i], 8'(30*i + 11), 8'(7*i + 3)};
            send(lote[i].op, lote[i].a, lote[i].b);
        end
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'd1; bus.cmd_b = 8'd1;
        repeat (3) begin
            @(negedge Tclk);
            chk("full_cmd_ready", bus.cmd_ready, 0);
            chk("full_ocupacao", ocupacao, 4);
            @(posedge Tclk); #1;
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_res(c);
            chk("order_data", bus.res_data, resultado(lote[i].op, lote[i].a, lote[i].b));
            chk("order_op", bus.res_op, lote[i].op);
            if (i > 0) chk("issue_gap", c, 4);
        end

        // reset while a command sits in ESPERA with two queued
        tick();
        send(3'd0, 8'd1, 8'd2);
        send(3'd1, 8'd3, 8'd4);
        send(3'd7, 8'd5, 8'd6);
        rst_n = 1'b0;
        @(negedge Tclk);
        chk("pre_rst_ocupacao", ocupacao, 2);
        chk("pre_rst_ula_en", ula_en, 1);
        chk("pre_rst_cmd_ready", bus.cmd_ready, 0);
        @(negedge Tclk);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_ocupacao", ocupacao, 0);
        chk("mid_rst_ula_en", ula_en, 0);
        chk("mid_rst_ula_clr", ula_clr, 1);
        @(posedge Tclk); #1; rst_n = 1'b1;
        repeat (15) begin
            @(negedge Tclk);
            chk("no_stale", bus.res_valid, 0);
        end

        // comparison sweep
        tick();
        for (int op = 2; op <= 6; op++) begin
            for (int p = 0; p < 2; p++) begin
                int a = (p == 0) ? 7 : 9;
                int b = (p == 0) ? 7 : 3;
                int e;
                case (op)
                    2:       e = (a > b)  ? 1 : 0;
                    3:       e = (a < b)  ? 1 : 0;
                    4:       e = (a >= b) ? 1 : 0;
                    5:       e = (a <= b) ? 1 : 0;
                    default: e = (a == b) ? 1 : 0;
                endcase
                send(3'(op), 8'(a), 8'(b));
                wait_res(c);
                chk("cmp_upper", 32'(bus.res_data) >> 9, 0);
                chk("cmp_low", 32'(bus.res_data) & 32'h1FF, e);
                tick();
            end
        end

        // randomized traffic, including occasional resets
        repeat (3000) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.cmd_valid = ($urandom_range(0, 9) < 6);
            bus.cmd_op    = 3'($urandom);
            bus.cmd_a     = 8'($urandom);
            bus.cmd_b     = 8'($urandom);
            bus.res_ready = ($urandom_range(0, 9) < 5);
            tick();
        end
        rst_n = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
